// File: rtl/seg7_pkg.sv
// Shared types, segment pattern table and helpers for the 7-segment scan display.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    localparam int DIGIT_SLOTS = 4;
    localparam int BCD_W       = 12;

    // Active-high patterns, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Map a BCD nibble to its active-high pattern; 10-15 cannot occur and decode to blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] pat;
        pat = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (nibble == 4'(i)) begin
                pat = SEG_DIGIT[i];
            end
        end
        return pat;
    endfunction

    // Double-dabble correction: every BCD nibble >= 5 gets +3 ahead of the left shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD digits.
// A new conversion starts only from IDLE when the input differs from the last one converted,
// so the displayed value always settles on the final stable input.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       value,
    output logic [BCD_W-1:0] disp_bcd,
    output logic             busy
);

    conv_state_t      state;
    logic [7:0]       shift_bin;
    logic [BCD_W-1:0] bcd;
    logic [2:0]       iter;
    logic [7:0]       last_value;

    // Conversion FSM: capture, 8 adjust-and-shift steps, then commit to the display register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift_bin  <= '0;
            bcd        <= '0;
            iter       <= '0;
            last_value <= '0;
            disp_bcd   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (value != last_value) begin
                        shift_bin  <= value;
                        last_value <= value;
                        bcd        <= '0;
                        iter       <= '0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, shift_bin} <= {dabble_adjust(bcd), shift_bin} << 1;
                    iter             <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    disp_bcd <= bcd;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// 4-digit common-anode 7-segment scan driver for an 8-bit count.
// Digit slots: 0 = ones, 1 = tens, 2 = hundreds, 3 = dark (fixes the duty cycle at 1/4).
// The first cycle of every slot keeps all anodes off to suppress ghosting.
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zero hundreds/tens digits.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SLOT_W  = $clog2(DIGIT_SLOTS);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]  DARK_SLOT = SLOT_W'(DIGIT_SLOTS - 1);

    // Inactive levels depend on the drive polarity of the board.
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("seg7_scan_display: REFRESH_DIV must be >= 2");
    end

    logic [PRESC_W-1:0]     prescaler;
    logic [SLOT_W-1:0]      slot;
    logic [BCD_W-1:0]       disp_bcd;
    logic [6:0]             digit_pat;
    logic [DIGIT_SLOTS-1:0] an_hot;

    bin2bcd_seq u_bcd (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .disp_bcd (disp_bcd),
        .busy     (busy)
    );

    // Select the digit pattern and anode for the current slot (active-high, pre-polarity).
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        digit_pat = SEG_BLANK;
        an_hot    = '0;
        case (slot)
            SLOT_W'(0): digit_pat = seg_decode(disp_bcd[3:0]);
            SLOT_W'(1): digit_pat = seg_decode(disp_bcd[7:4]);
            SLOT_W'(2): digit_pat = seg_decode(disp_bcd[11:8]);
            default:    digit_pat = SEG_BLANK;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == SLOT_W'(2) && disp_bcd[11:8] == 4'd0) begin
            digit_pat = SEG_BLANK;
        end
        if (slot == SLOT_W'(1) && disp_bcd[11:4] == 8'd0) begin
            digit_pat = SEG_BLANK;
        end
`endif
        if (prescaler != '0 && slot != DARK_SLOT) begin
            an_hot[slot] = 1'b1;
        end
    end

    // Prescaler/slot scan counters and registered pin drive with polarity applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            slot      <= '0;
            seg       <= SEG_OFF;
            an        <= AN_OFF;
            dp        <= DP_OFF;
        end else begin
            if (prescaler == PRESC_MAX) begin
                prescaler <= '0;
                slot      <= slot + SLOT_W'(1);
            end else begin
                prescaler <= prescaler + PRESC_W'(1);
            end
            seg <= SEG_ACTIVE_LOW ? ~digit_pat : digit_pat;
            an  <= SEG_ACTIVE_LOW ? ~an_hot : an_hot;
            dp  <= DP_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with REFRESH_DIV=4, active-low drive.
// Expected BCD results are queued when a value is driven and popped when a conversion commits.
module tb_seg7_scan_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_q [$];
    logic [3:0]  an_q  [$];
    logic [6:0]  seg_q [$];

    // Active-low digit patterns for '0'..'9'.
    localparam logic [6:0] SEG_AL [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_DARK = 7'h7F;

    // Anode sequence over one full scan period starting at the first edge after reset.
    localparam logic [3:0] AN_SEQ [0:15] = '{
        4'hF, 4'hE, 4'hE, 4'hE,
        4'hF, 4'hD, 4'hD, 4'hD,
        4'hF, 4'hB, 4'hB, 4'hB,
        4'hF, 4'hF, 4'hF, 4'hF
    };

    seg7_scan_display #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .seg   (seg),
        .an    (an),
        .dp    (dp),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected active-low segment drive for one slot of a BCD value.
    function automatic logic [6:0] exp_seg(input logic [11:0] bcd, input int slot);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = bcd[11:8];
        t = bcd[7:4];
        o = bcd[3:0];
        case (slot)
            0: return SEG_AL[o];
`ifdef LEADING_ZERO_BLANK_EN
            1: return (h == 4'd0 && t == 4'd0) ? SEG_DARK : SEG_AL[t];
            2: return (h == 4'd0) ? SEG_DARK : SEG_AL[h];
`else
            1: return SEG_AL[t];
            2: return SEG_AL[h];
`endif
            default: return SEG_DARK;
        endcase
    endfunction

    // Wait (bounded) for busy to rise and fall again; report cycles and busy-high count.
    task automatic wait_done(output int elapsed, output int hi_cnt);
        bit seen;
        bit ok;
        seen    = 1'b0;
        ok      = 1'b0;
        elapsed = 0;
        hi_cnt  = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            elapsed++;
            if (busy) begin
                seen = 1'b1;
                hi_cnt++;
            end else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
        check("conv_complete", 32'(ok), 32'd1);
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(dut.u_bcd.disp_bcd), 32'hFFFF_FFFF);
        end else begin
            check(tag, 32'(dut.u_bcd.disp_bcd), 32'(exp_q.pop_front()));
        end
    endtask

    // Wait (bounded) until the anodes select a slot, then check that slot's segments.
    task automatic show_slot(input int slot, input logic [6:0] expected, input string tag);
        bit         found;
        logic [3:0] want;
        found = 1'b0;
        want  = ~(4'b0001 << slot);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (an === want) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_found"}, 32'(found), 32'd1);
        check(tag, 32'(seg), 32'(expected));
    endtask

    initial begin
        int elapsed;
        int hi_cnt;
        int total;

        reset = 1'b1;
        value = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Reset asserted between edges while scanning and converting.
        value = 8'd200;
        repeat (4) @(negedge clk);
        check("busy_mid_conv", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_seg", 32'(seg), 32'h7F);
        check("async_rst_dp", 32'(dp), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_bcd", 32'(dut.u_bcd.disp_bcd), 32'h000);
        value = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_hold_an", 32'(an), 32'hF);
        check("rst_hold_busy", 32'(busy), 32'd0);
        check("rst_hold_bcd", 32'(dut.u_bcd.disp_bcd), 32'h000);
        reset = 1'b0;

        // Scan pattern with a static value of 0, a little beyond one full period.
        for (int k = 0; k < 20; k++) begin
            an_q.push_back(AN_SEQ[k % 16]);
            seg_q.push_back(exp_seg(12'h000, (k % 16) / 4));
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("scan_an_%0d", k), 32'(an), 32'(an_q.pop_front()));
            check($sformatf("scan_seg_%0d", k), 32'(seg), 32'(seg_q.pop_front()));
        end

        // 0 -> 255: busy for 9 cycles, committed after 10 clocks.
        value = 8'd255;
        exp_q.push_back(12'h255);
        wait_done(elapsed, hi_cnt);
        check("lat_255", 32'(elapsed), 32'd10);
        check("busy_cycles_255", 32'(hi_cnt), 32'd9);
        pop_check("bcd_255");
        show_slot(0, exp_seg(12'h255, 0), "seg_255_ones");
        show_slot(2, exp_seg(12'h255, 2), "seg_255_hundreds");

        // 7: leading-zero behaviour on tens/hundreds.
        value = 8'd7;
        exp_q.push_back(12'h007);
        wait_done(elapsed, hi_cnt);
        pop_check("bcd_7");
        show_slot(0, exp_seg(12'h007, 0), "seg_7_ones");
        show_slot(1, exp_seg(12'h007, 1), "seg_7_tens");
        show_slot(2, exp_seg(12'h007, 2), "seg_7_hundreds");

        // 10 then 99 two cycles later: second change is picked up after the first commit.
        value = 8'd10;
        exp_q.push_back(12'h010);
        @(negedge clk);
        @(negedge clk);
        value = 8'd99;
        exp_q.push_back(12'h099);
        wait_done(elapsed, hi_cnt);
        total = 2 + elapsed;
        check("lat_010", 32'(total), 32'd10);
        pop_check("bcd_010");
        @(negedge clk);
        total++;
        check("busy_gap_one_cycle", 32'(busy), 32'd1);
        wait_done(elapsed, hi_cnt);
        total += elapsed;
        pop_check("bcd_099");
        check("lat_099_within_21", 32'(total <= 21), 32'd1);
        show_slot(1, exp_seg(12'h099, 1), "seg_99_tens");

        // Upstream wrap 255 -> 0.
        value = 8'd255;
        exp_q.push_back(12'h255);
        wait_done(elapsed, hi_cnt);
        pop_check("bcd_255_again");
        value = 8'd0;
        exp_q.push_back(12'h000);
        wait_done(elapsed, hi_cnt);
        check("busy_cycles_wrap", 32'(hi_cnt), 32'd9);
        pop_check("bcd_wrap_0");
        show_slot(0, exp_seg(12'h000, 0), "seg_0_ones");
        show_slot(1, exp_seg(12'h000, 1), "seg_0_tens");
        show_slot(2, exp_seg(12'h000, 2), "seg_0_hundreds");
        check("dp_inactive", 32'(dp), 32'd1);

        // Stable value: no further conversion starts.
        repeat (4) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
